// File: rtl/thee_clk_gen.sv
// -----------------------------------------------------------------------------
// thee_clk_gen
//
// Numerically-controlled clock generator. A phase accumulator advances by a
// programmable increment each enabled reference cycle; its MSB is the generated
// square wave. The default increment is derived at elaboration from
// FREQ * FREQ_UNIT relative to REF_FREQ_HZ.
//
// Optional feature (macro THEE_CLK_GEN_MEAS_EN): an edge-count measurement unit
// that counts rising edges of clk_out over MEAS_WINDOW reference cycles and
// publishes the count once per window. Without the macro the measurement ports
// are tied to zero.
//
// Ports:
//   clk        in   reference clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   en         in   accumulator advance enable
//   inc_load   in   load inc_val as the new phase increment
//   inc_val    in   runtime phase increment (clamped to 2^(ACC_W-1))
//   clk_out    out  generated square wave (accumulator MSB, registered)
//   rise_pulse out  one-cycle pulse in the cycle clk_out goes 0->1
//   meas_count out  rising edges counted in the last window
//   meas_valid out  one-cycle pulse when meas_count updates
// -----------------------------------------------------------------------------
module thee_clk_gen #(
   parameter int  FREQ        = 93,
   parameter real FREQ_UNIT   = 1e6,
   parameter real REF_FREQ_HZ = 1e9,
   parameter int  ACC_W       = 32,
   parameter int  MEAS_WINDOW = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inc_load,
   input  logic [ACC_W-1:0] inc_val,
   output logic             clk_out,
   output logic             rise_pulse,
   output logic [15:0]      meas_count,
   output logic             meas_valid
);

   // Requested output frequency and the matching increment, rounded to nearest.
   localparam real F_OUT_HZ = FREQ * FREQ_UNIT;
   localparam real INC_REAL = F_OUT_HZ / REF_FREQ_HZ * (2.0 ** ACC_W);
   localparam longint INC_DEFAULT_L = longint'($floor(INC_REAL + 0.5));
   localparam logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_L);

   // Half a turn per cycle is the fastest meaningful rate (output = ref/2).
   localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

   if (F_OUT_HZ <= 0.0 || F_OUT_HZ > REF_FREQ_HZ / 2.0) begin : g_bad_freq
      $fatal(1, "thee_clk_gen: FREQ*FREQ_UNIT must be in (0, REF_FREQ_HZ/2]");
   end

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic             clk_out_q, clk_out_d;
   logic             rise_pulse_q, rise_pulse_d;
   logic [ACC_W-1:0] acc_sum;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      acc_sum      = acc_q + inc_q;   // wraps modulo 2^ACC_W
      acc_d        = acc_q;
      clk_out_d    = clk_out_q;
      rise_pulse_d = 1'b0;
      inc_d        = inc_q;

      if (en) begin
         acc_d        = acc_sum;
         clk_out_d    = acc_sum[ACC_W-1];
         rise_pulse_d = acc_sum[ACC_W-1] & ~clk_out_q;
      end

      // The current cycle's addition already used the old increment above.
      if (inc_load) begin
         inc_d = (inc_val > INC_MAX) ? INC_MAX : inc_val;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         inc_q        <= INC_DEFAULT;
         clk_out_q    <= 1'b0;
         rise_pulse_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         inc_q        <= inc_d;
         clk_out_q    <= clk_out_d;
         rise_pulse_q <= rise_pulse_d;
      end
   end

   assign clk_out    = clk_out_q;
   assign rise_pulse = rise_pulse_q;

`ifdef THEE_CLK_GEN_MEAS_EN
   localparam int WIN_W = (MEAS_WINDOW > 1) ? $clog2(MEAS_WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MEAS_WINDOW - 1);

   logic [WIN_W-1:0] win_q, win_d;
   logic [15:0]      edges_q, edges_d;
   logic [15:0]      edges_sum;
   logic [15:0]      meas_count_q, meas_count_d;
   logic             meas_valid_q, meas_valid_d;

   always_comb begin
      // Saturating count including the pulse visible in this cycle.
      edges_sum    = (rise_pulse_q && edges_q != 16'hFFFF) ? edges_q + 16'd1 : edges_q;
      win_d        = win_q + 1'b1;
      edges_d      = edges_sum;
      meas_count_d = meas_count_q;
      meas_valid_d = 1'b0;

      if (win_q == WIN_LAST) begin
         win_d        = '0;
         edges_d      = '0;
         meas_count_d = edges_sum;
         meas_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q        <= '0;
         edges_q      <= '0;
         meas_count_q <= '0;
         meas_valid_q <= 1'b0;
      end else begin
         win_q        <= win_d;
         edges_q      <= edges_d;
         meas_count_q <= meas_count_d;
         meas_valid_q <= meas_valid_d;
      end
   end

   assign meas_count = meas_count_q;
   assign meas_valid = meas_valid_q;
`else
   assign meas_count = 16'd0;
   assign meas_valid = 1'b0;
`endif

endmodule

// File: tb/tb_thee_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_thee_clk_gen
//
// Bench for thee_clk_gen at 100 MHz reference / 25 MHz requested output
// (default increment 0x4000_0000) with a 100-cycle measurement window.
// A phase-fraction model tracks the expected outputs each cycle; directed
// sequences with literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_thee_clk_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        inc_load;
   logic [31:0] inc_val;
   logic        clk_out;
   logic        rise_pulse;
   logic [15:0] meas_count;
   logic        meas_valid;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   always #5 clk = ~clk;

   thee_clk_gen #(
      .FREQ       (25),
      .FREQ_UNIT  (1e6),
      .REF_FREQ_HZ(100e6),
      .ACC_W      (32),
      .MEAS_WINDOW(100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .inc_load  (inc_load),
      .inc_val   (inc_val),
      .clk_out   (clk_out),
      .rise_pulse(rise_pulse),
      .meas_count(meas_count),
      .meas_valid(meas_valid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: phase is a fraction of a turn held as an integer over 2^32; the
   // output is high in the second half of the turn. Edge counts are summed per
   // 100-cycle window measured from reset release.
   // ---------------------------------------------------------------------------
   localparam longint TURN = 64'h1_0000_0000;
   longint m_phase, m_inc, m_tick, m_sum;
   bit     m_out, m_rise, m_valid, new_out;
   int     m_count;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_inc = 64'h4000_0000; m_out = 0; m_rise = 0;
         m_tick = 0; m_sum = 0; m_count = 0; m_valid = 0;
      end else begin
`ifdef THEE_CLK_GEN_MEAS_EN
         m_sum = m_sum + (m_rise ? 1 : 0);
         if (m_sum > 65535) m_sum = 65535;
         m_valid = ((m_tick % 100) == 99);
         if (m_valid) begin
            m_count = int'(m_sum);
            m_sum   = 0;
         end
         m_tick++;
`endif
         if (en) begin
            m_phase = (m_phase + m_inc) % TURN;
            new_out = (m_phase >= TURN / 2);
            m_rise  = new_out && !m_out;
            m_out   = new_out;
         end else begin
            m_rise = 0;
         end
         if (inc_load) m_inc = (longint'(inc_val) > TURN / 2) ? TURN / 2 : longint'(inc_val);
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("clk_out",    clk_out,    m_out);
         check("rise_pulse", rise_pulse, m_rise);
         check("meas_count", meas_count, m_count);
         check("meas_valid", meas_valid, m_valid);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus. Inputs change 1 ns after the rising edge; literal
   // checks read outputs at that point (they reflect the edge just taken).
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (meas_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   bit exp_start[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
   bit exp_rstart[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
   bit exp_resume[4] = '{1, 0, 0, 1};
   bit exp_p8[12]    = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
   bit exp_tog[6]    = '{1, 0, 1, 0, 1, 0};
   bit exp_after[4]  = '{0, 1, 1, 0};
   bit ok;

   initial begin
      rst = 1'b1; en = 1'b0; inc_load = 1'b0; inc_val = '0;
      repeat (3) tick();
      cmp_on = 1'b1;
      check("reset_clk_out", clk_out, 1'b0);
      check("reset_rise", rise_pulse, 1'b0);
      check("reset_meas_count", meas_count, 16'd0);
      check("reset_meas_valid", meas_valid, 1'b0);

      // Default increment: period 4, high 2.
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("start_clk_out", clk_out, exp_start[i]);
         check("start_rise", rise_pulse, exp_rstart[i]);
      end

      // Advance into a high phase, then pause for 5 cycles.
      repeat (2) tick();
      check("pre_pause_high", clk_out, 1'b1);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pause_clk_out", clk_out, 1'b1);
         check("pause_rise", rise_pulse, 1'b0);
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("resume_clk_out", clk_out, exp_resume[i]);
      end

      // Halve the increment: load cycle still uses the old one.
      inc_load = 1'b1; inc_val = 32'h2000_0000;
      tick();
      check("load_cycle_clk_out", clk_out, 1'b1);
      inc_load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("p8_clk_out", clk_out, exp_p8[i]);
      end

      // Oversized increment is clamped to half a turn: toggles every cycle.
      inc_load = 1'b1; inc_val = 32'hFFFF_FFFF;
      tick();
      check("clamp_load_clk_out", clk_out, 1'b0);
      inc_load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("clamp_clk_out", clk_out, exp_tog[i]);
         check("clamp_rise", rise_pulse, exp_tog[i]);
      end

      // Reset wins over load and enable; default increment returns.
      rst = 1'b1; inc_load = 1'b1; inc_val = 32'h1234_5678;
      tick();
      check("rst_prio_clk_out", clk_out, 1'b0);
      check("rst_prio_rise", rise_pulse, 1'b0);
      check("rst_prio_meas_count", meas_count, 16'd0);
      rst = 1'b0; inc_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("after_rst_clk_out", clk_out, exp_after[i]);
      end

`ifdef THEE_CLK_GEN_MEAS_EN
      wait_valid("meas_win1", ok);
      if (ok) check("meas_count_25", meas_count, 16'd25);
      wait_valid("meas_win2", ok);
      if (ok) check("meas_count_25b", meas_count, 16'd25);

      // Freeze the accumulator; the first full frozen window counts nothing.
      inc_load = 1'b1; inc_val = 32'h0;
      tick();
      inc_load = 1'b0;
      wait_valid("meas_win3", ok);
      wait_valid("meas_win4", ok);
      if (ok) check("meas_count_zero", meas_count, 16'd0);
`else
      repeat (120) begin
         tick();
         check("meas_valid_tied", meas_valid, 1'b0);
      end
      check("meas_count_tied", meas_count, 16'd0);
`endif

      tick();
      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
